// File: rtl/mult_sequencer.sv
// Control sequencer for the 4x4 shift-add multiplier datapath.
// Walks LOAD, INIT, four ITER steps, OUT and DONE, driving the datapath control lines.
module mult_sequencer (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic start,
    input  logic flag,
    output logic busy,
    output logic done,
    output logic enA,
    output logic enB,
    output logic enDPO,
    output logic ABsel,
    output logic sr_c1,
    output logic sr_c0,
    output logic enSR,
    output logic SRsel,
    output logic alu_c2,
    output logic alu_c1,
    output logic alu_c0,
    output logic enACC,
    output logic clrACC
);

    localparam int unsigned K_W   = 2;
    localparam int unsigned ALU_W = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_INIT = 3'd2,
        S_ITER = 3'd3,
        S_OUT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           r_state;
    logic [K_W-1:0]   r_k;
    logic [ALU_W-1:0] w_alu;

    // State register and iteration counter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) r_state <= S_LOAD;
                S_LOAD: r_state <= S_INIT;
                S_INIT: begin
                    r_k     <= '0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    if (r_k == K_W'(3)) begin
                        r_state <= S_OUT;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                S_OUT:  r_state <= S_DONE;
                S_DONE: r_state <= start ? S_LOAD : S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Control decode; in ITER the add term follows the current multiplier LSB
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        enA    = 1'b0;
        enB    = 1'b0;
        enDPO  = 1'b0;
        ABsel  = 1'b0;
        sr_c1  = 1'b0;
        sr_c0  = 1'b0;
        enSR   = 1'b0;
        SRsel  = 1'b0;
        enACC  = 1'b0;
        clrACC = 1'b0;
        w_alu  = '0;
        case (r_state)
            S_LOAD: begin
                busy = 1'b1;
                enA  = 1'b1;
                enB  = 1'b1;
            end
            S_INIT: begin
                busy   = 1'b1;
                ABsel  = 1'b1;
                sr_c1  = 1'b1;
                sr_c0  = 1'b1;
                enSR   = 1'b1;
                clrACC = 1'b1;
            end
            S_ITER: begin
                busy  = 1'b1;
                sr_c0 = 1'b1;
                enSR  = 1'b1;
                if (flag) begin
                    w_alu = ALU_W'(r_k) + ALU_W'(1);
                    enACC = 1'b1;
                end
            end
            S_OUT: begin
                busy  = 1'b1;
                enDPO = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign alu_c2 = w_alu[2];
    assign alu_c1 = w_alu[1];
    assign alu_c0 = w_alu[0];

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Control-path sequencer for the 4x4 shift-add multiplier datapath. It accepts a start request, loads the operands, and steps the datapath through one clear/load cycle, four conditional-add/shift iterations and one output-register write. It reports completion with a busy/done handshake. It sits between the top-level wrapper, which supplies `start` and the operands, and the multiplier datapath, which it drives with thirteen control lines and which returns `flag`.

## Interface
- No parameters; operand width fixed at 4 bits, iteration count fixed at 4.
- `sys_clk`  in  1  single clock; all state changes on rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply; sampled in IDLE and DONE only.
- `flag`  in  1  datapath SR[0], the current multiplier LSB.
- `busy`  out  1  high from LOAD through OUT.
- `done`  out  1  one-cycle pulse in DONE; product valid on datapath `MP`.
- `enA`, `enB`  out  1 each  load datapath A/B registers from operand inputs.
- `enDPO`  out  1  load output register from ACC.
- `ABsel`  out  1  SR parallel-load mux: 0 = {4'b0,A}, 1 = {4'b0,B}.
- `sr_c1`, `sr_c0`  out  1 each  SR mode: 00 hold, 01 shift right (zero fill), 10 shift left, 11 parallel load.
- `enSR`  out  1  SR update enable.
- `SRsel`  out  1  SR load source: 0 = AB mux, 1 = ACC. Always 0 from this block.
- `alu_c2..alu_c0`  out  3  ALU op: 000 = ACC pass, 001/010/011/100 = ACC + (A << 0/1/2/3), others unused.
- `enACC`  out  1  ACC <= ALU result.
- `clrACC`  out  1  ACC <= 0; wins over `enACC`.

## Operation
- States: IDLE, LOAD, INIT, ITER, OUT, DONE. There is a 2-bit iteration counter `k`.
- Outputs are decoded from the state register. In ITER, `alu_c` and `enACC` also depend on `flag`. Every control line not listed for a state is 0.
- IDLE: all outputs 0. If `start`=1, go to LOAD; otherwise stay.
- LOAD: `enA`=`enB`=1, `busy`=1. Go to INIT.
- INIT: `ABsel`=1, `SRsel`=0, `sr_c1,sr_c0`=11, `enSR`=1, `clrACC`=1, `busy`=1. Set `k`=0 and go to ITER.
- ITER: `sr_c1,sr_c0`=01, `enSR`=1, `busy`=1.
  - If `flag`=1: `alu_c`=k+1 and `enACC`=1.
  - If `flag`=0: `alu_c`=000 and `enACC`=0.
  - `flag` is SR[0] before this cycle's shift.
  - If `k`=3, go to OUT. Otherwise `k`<=k+1 and stay in ITER.
- OUT: `enDPO`=1, `busy`=1. Go to DONE.
- DONE: `done`=1, `busy`=0. If `start`=1, go to LOAD (back-to-back). Otherwise go to IDLE.
- `start` is ignored in LOAD, INIT, ITER and OUT; it is not queued.
- Product arithmetic: ACC is 8 bits and the sum of A<<k terms is at most 225, so there is no overflow. Final ACC = A*B.

## Timing
- Reset: next edge gives state IDLE, `k`=0, and every output 0 (including `busy` and `done`).
- Reset mid-operation (any state): abort at the next edge to IDLE with all outputs 0. Datapath register contents are not touched by this block; the next operation reloads everything.
- Reset asserted together with `start`: reset wins and the block stays in IDLE.
- Latency: if `start` is high at edge 0 in IDLE, the state sequence is LOAD(c1), INIT(c2), ITER k=0..3 (c3–c6), OUT(c7), DONE(c8).
  - `done` is high during c8.
  - `MP` holds A*B from c8 until the next OUT.
- `busy` is high during c1–c7.
- Back-to-back throughput: one product per 8 cycles when `start` is held high.
- Operands must be stable on the datapath inputs in the LOAD cycle only.

## Test plan
- Reset, then idle with `start`=0 for 5 cycles -> all outputs 0, `busy`=0, `done` never pulses.
- A=13, B=11, one-cycle `start` -> `flag` sequence 1,1,0,1 gives `alu_c` 001,010,000,100 with `enACC` 1,1,0,1; `done` in c8; `MP`=143.
- A=15, B=15 -> `alu_c` 001..100 every iteration, `MP`=225. A=0, B=9 -> `MP`=0. A=7, B=0 -> `enACC` never high, `MP`=0.
- `start` held high over three operations (3x5, 6x9, 15x1) -> `done` every 8 cycles; `MP` = 15, 54, 15; no idle cycle between LOAD states.
- `start` pulsed during ITER -> ignored; exactly one `done`, then return to IDLE.
- `sys_rst` asserted during ITER k=2 -> next cycle IDLE with all outputs 0 and no `done`. A fresh start with 4x4 then gives `MP`=16 with normal latency.
